// File: rtl/nn_selftest_engine_pkg.sv
// Shared definitions for the zyNet self-test engine: FSM encoding, default
// result register address and small width/arithmetic helpers.
package nn_selftest_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_STREAM,
        ST_WAIT_INT,
        ST_AR,
        ST_R,
        ST_CHECK,
        ST_DONE
    } state_t;

    localparam logic [31:0] RESULT_ADDR_DEFAULT = 32'h8;

    // Bits needed to index n items, never less than 1 so ports stay legal.
    function automatic int clog2w(input int n);
        int w;
        w = 0;
        while ((1 << w) < n) begin
            w++;
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/nn_selftest_engine_skid_fifo.sv
// Two-entry FIFO between the image BRAM and the AXI-Stream master; holds
// reads that are already in flight when the consumer stalls.
module nn_axis_skid_fifo #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              head_valid,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
            end
            wr_ptr <= wr_ptr ^ push;
            rd_ptr <= rd_ptr ^ pop;
            count  <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head_data  = mem[rd_ptr];
    assign head_valid = (count != 2'd0);

endmodule

// File: rtl/nn_selftest_engine.sv
// Self-test sequencer: streams stored images into zyNet, reads back the
// detected class after each interrupt and tallies right/wrong answers.
module nn_selftest_engine
    import nn_selftest_engine_pkg::*;
#(
    parameter int          DATA_W      = 16,
    parameter int          IMG_LEN     = 784,
    parameter int          NUM_SAMPLES = 100,
    parameter int          LABEL_W     = 8,
    parameter logic [31:0] RESULT_ADDR = RESULT_ADDR_DEFAULT,
    parameter int          TIMEOUT_CYC = 65536,
    parameter int          ADDR_W      = clog2w(IMG_LEN * NUM_SAMPLES),
    parameter int          LBL_AW      = clog2w(NUM_SAMPLES)
) (
    input  logic               s_axi_aclk,
    input  logic               s_axi_aresetn,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic [ADDR_W-1:0]  img_addr,
    output logic               img_rd,
    input  logic [DATA_W-1:0]  img_data,
    output logic [LBL_AW-1:0]  lbl_addr,
    input  logic [LABEL_W-1:0] lbl_data,
    output logic [DATA_W-1:0]  m_axis_tdata,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    input  logic               intr,
    output logic [31:0]        m_axi_araddr,
    output logic               m_axi_arvalid,
    input  logic               m_axi_arready,
    input  logic [31:0]        m_axi_rdata,
    input  logic               m_axi_rvalid,
    output logic               m_axi_rready,
    output logic [15:0]        right_cnt,
    output logic [15:0]        wrong_cnt,
    output logic               timeout_err
);

    localparam int                IDX_W       = clog2w(IMG_LEN + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(IMG_LEN - 1);
    localparam logic [IDX_W-1:0]  IMG_LEN_I   = IDX_W'(IMG_LEN);
    localparam logic [ADDR_W-1:0] IMG_LEN_A   = ADDR_W'(IMG_LEN);
    localparam logic [LBL_AW-1:0] LAST_SAMPLE = LBL_AW'(NUM_SAMPLES - 1);

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   base;
    logic [IDX_W-1:0]    rd_idx;
    logic [IDX_W-1:0]    beat_idx;
    logic [LBL_AW-1:0]   sample;
    logic                rd_pend;
    logic                intr_q;
    logic                intr_pend;
    logic                timed_out;
    logic [31:0]         to_cnt;
    logic [LABEL_W-1:0]  rdata_q;
    logic [1:0]          fifo_count;
    logic [2:0]          occ_after;
    logic                intr_rise;
    logic                beat_fire;
    logic                last_beat;
    logic                timeout_hit;
    logic                unused_rdata_hi;

    assign unused_rdata_hi = ^m_axi_rdata[31:LABEL_W];

    nn_axis_skid_fifo #(
        .DATA_W(DATA_W)
    ) u_fifo (
        .clk       (s_axi_aclk),
        .rst_n     (s_axi_aresetn),
        .push      (rd_pend),
        .push_data (img_data),
        .pop       (beat_fire),
        .head_data (m_axis_tdata),
        .head_valid(m_axis_tvalid),
        .count     (fifo_count)
    );

    assign intr_rise   = intr & ~intr_q;
    assign beat_fire   = m_axis_tvalid & m_axis_tready;
    assign last_beat   = beat_fire && (beat_idx == LAST_IDX);
    assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt == 32'(TIMEOUT_CYC - 1));

    // A read may only be issued if its data is guaranteed a FIFO slot once it lands.
    assign occ_after = {1'b0, fifo_count} + {2'b00, rd_pend} - {2'b00, beat_fire};
    assign img_rd    = (state == ST_STREAM) && (rd_idx < IMG_LEN_I) && (occ_after < 3'd2);
    assign img_addr  = base + ADDR_W'(rd_idx);

    assign busy          = (state != ST_IDLE) && (state != ST_DONE);
    assign done          = (state == ST_DONE);
    assign m_axi_arvalid = (state == ST_AR);
    assign m_axi_araddr  = (state == ST_AR) ? RESULT_ADDR : 32'd0;
    assign m_axi_rready  = (state == ST_R);
    assign lbl_addr      = sample;

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:     if (start) state_next = ST_STREAM;
            ST_STREAM:   if (last_beat) state_next = ST_WAIT_INT;
            ST_WAIT_INT: begin
                if (intr_rise || intr_pend) begin
                    state_next = ST_AR;
                end else if (timeout_hit) begin
                    state_next = ST_CHECK;
                end
            end
            ST_AR:       if (m_axi_arready) state_next = ST_R;
            ST_R:        if (m_axi_rvalid) state_next = ST_CHECK;
            ST_CHECK:    state_next = (sample == LAST_SAMPLE) ? ST_DONE : ST_STREAM;
            ST_DONE:     state_next = ST_IDLE;
            default:     state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
        if (!s_axi_aresetn) begin
            base        <= '0;
            rd_idx      <= '0;
            beat_idx    <= '0;
            sample      <= '0;
            rd_pend     <= 1'b0;
            intr_q      <= 1'b0;
            intr_pend   <= 1'b0;
            timed_out   <= 1'b0;
            to_cnt      <= '0;
            rdata_q     <= '0;
            right_cnt   <= '0;
            wrong_cnt   <= '0;
            timeout_err <= 1'b0;
        end else begin
            intr_q  <= intr;
            rd_pend <= img_rd;
            to_cnt  <= (state == ST_WAIT_INT) ? to_cnt + 32'd1 : 32'd0;
            if (img_rd) begin
                rd_idx <= rd_idx + IDX_W'(1);
            end
            if (beat_fire) begin
                beat_idx <= beat_idx + IDX_W'(1);
            end
            // An interrupt that beats the last pixel is remembered for WAIT_INT.
            if ((state == ST_STREAM) && intr_rise && ((beat_idx != '0) || beat_fire)) begin
                intr_pend <= 1'b1;
            end
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        base        <= '0;
                        rd_idx      <= '0;
                        beat_idx    <= '0;
                        sample      <= '0;
                        intr_pend   <= 1'b0;
                        timed_out   <= 1'b0;
                        right_cnt   <= '0;
                        wrong_cnt   <= '0;
                        timeout_err <= 1'b0;
                    end
                end
                ST_WAIT_INT: begin
                    if (intr_rise || intr_pend) begin
                        intr_pend <= 1'b0;
                    end else if (timeout_hit) begin
                        timeout_err <= 1'b1;
                        timed_out   <= 1'b1;
                        wrong_cnt   <= sat_inc(wrong_cnt);
                    end
                end
                ST_R: begin
                    if (m_axi_rvalid) begin
                        rdata_q <= m_axi_rdata[LABEL_W-1:0];
                    end
                end
                ST_CHECK: begin
                    if (!timed_out) begin
                        if (rdata_q == lbl_data) begin
                            right_cnt <= sat_inc(right_cnt);
                        end else begin
                            wrong_cnt <= sat_inc(wrong_cnt);
                        end
                    end
                    timed_out <= 1'b0;
                    intr_pend <= 1'b0;
                    base      <= base + IMG_LEN_A;
                    rd_idx    <= '0;
                    beat_idx  <= '0;
                    sample    <= sample + LBL_AW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
